// File: rtl/piece_fit_checker.sv
// Tetris-style piece collision checker: scans the 4x4 piece one cell per cycle
// against a captured playfield. Optional macro PIECE_FIT_COUNT_EN adds hit_count.
module piece_fit_checker #(
   parameter int unsigned FIELD_W = 10,
   parameter int unsigned FIELD_H = 20,
   parameter int unsigned POS_W   = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [15:0]                block,
   input  logic [FIELD_W*FIELD_H-1:0] field,
   input  logic [POS_W-1:0]           pos_x,
   input  logic [POS_W-1:0]           pos_y,
   input  logic [1:0]                 rotate,
   output logic                       busy,
   output logic                       done,
   output logic                       fit,
   output logic [POS_W:0]             hit_x,
   output logic [POS_W:0]             hit_y
`ifdef PIECE_FIT_COUNT_EN
   ,
   output logic [4:0]                 hit_count
`endif
);

   localparam int unsigned CELLS = FIELD_W * FIELD_H;
   localparam int unsigned IDX_W = $clog2(CELLS);
   localparam int unsigned XY_W  = POS_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [3:0]         k, k_n;
   logic [15:0]        block_q, block_n;
   logic [CELLS-1:0]   field_q, field_n;
   logic [POS_W-1:0]   pos_x_q, pos_x_n;
   logic [POS_W-1:0]   pos_y_q, pos_y_n;
   logic [1:0]         rot_q, rot_n;
   logic               found_q, found_n;
   logic [XY_W-1:0]    work_x_q, work_x_n;
   logic [XY_W-1:0]    work_y_q, work_y_n;
   logic               busy_n, done_n, fit_n;
   logic [XY_W-1:0]    hit_x_n, hit_y_n;
`ifdef PIECE_FIT_COUNT_EN
   logic [4:0]         cnt_q, cnt_n;
   logic [4:0]         hit_count_n;
`endif

   logic [1:0]         bx_c, by_c;
   logic [3:0]         src_c;
   logic [XY_W-1:0]    cell_x_c, cell_y_c;
   logic               in_bounds_c;
   logic [IDX_W-1:0]   cell_idx_c;
   logic               collide_c;
   logic               last_c;

   // Evaluate the current cell k: rotated source bit, board coordinates, collision.
   always_comb begin
      bx_c = k[1:0];
      by_c = k[3:2];
      unique case (rot_q)
         2'd0:    src_c = {by_c, bx_c};
         2'd1:    src_c = 4'd12 + 4'(by_c) - {bx_c, 2'b00};
         2'd2:    src_c = 4'd15 - {by_c, 2'b00} - 4'(bx_c);
         default: src_c = 4'd3 - 4'(by_c) + {bx_c, 2'b00};
      endcase
      cell_x_c    = XY_W'(pos_x_q) + XY_W'(bx_c);
      cell_y_c    = XY_W'(pos_y_q) + XY_W'(by_c);
      in_bounds_c = (32'(cell_x_c) < FIELD_W) && (32'(cell_y_c) < FIELD_H);
      // Out-of-bounds cells resolve to index 0 and are masked, so field is never read for them.
      cell_idx_c  = in_bounds_c ? IDX_W'(32'(cell_y_c) * FIELD_W + 32'(cell_x_c)) : '0;
      collide_c   = block_q[src_c] && (!in_bounds_c || field_q[cell_idx_c]);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n  = state;
      k_n      = k;
      block_n  = block_q;
      field_n  = field_q;
      pos_x_n  = pos_x_q;
      pos_y_n  = pos_y_q;
      rot_n    = rot_q;
      found_n  = found_q;
      work_x_n = work_x_q;
      work_y_n = work_y_q;
      done_n   = 1'b0;
      fit_n    = fit;
      hit_x_n  = hit_x;
      hit_y_n  = hit_y;
      last_c   = 1'b0;
`ifdef PIECE_FIT_COUNT_EN
      cnt_n       = cnt_q;
      hit_count_n = hit_count;
`endif

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n  = SCAN;
               k_n      = 4'd0;
               block_n  = block;
               field_n  = field;
               pos_x_n  = pos_x;
               pos_y_n  = pos_y;
               rot_n    = rotate;
               found_n  = 1'b0;
               work_x_n = '0;
               work_y_n = '0;
`ifdef PIECE_FIT_COUNT_EN
               cnt_n    = 5'd0;
`endif
            end
         end
         SCAN: begin
            k_n = k + 4'd1;
            if (collide_c && !found_q) begin
               found_n  = 1'b1;
               work_x_n = cell_x_c;
               work_y_n = cell_y_c;
            end
`ifdef PIECE_FIT_COUNT_EN
            cnt_n  = cnt_q + 5'(collide_c);
            last_c = (k == 4'd15);
`else
            last_c = (k == 4'd15) || collide_c;
`endif
            if (last_c) begin
               state_n = DONE;
               done_n  = 1'b1;
               fit_n   = !(found_q || collide_c);
               hit_x_n = found_q ? work_x_q : (collide_c ? cell_x_c : '0);
               hit_y_n = found_q ? work_y_q : (collide_c ? cell_y_c : '0);
`ifdef PIECE_FIT_COUNT_EN
               hit_count_n = cnt_q + 5'(collide_c);
`endif
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n == SCAN);
   end

   // State and output registers; reset overrides everything including an active scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         k        <= 4'd0;
         block_q  <= '0;
         field_q  <= '0;
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         rot_q    <= '0;
         found_q  <= 1'b0;
         work_x_q <= '0;
         work_y_q <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         fit      <= 1'b0;
         hit_x    <= '0;
         hit_y    <= '0;
`ifdef PIECE_FIT_COUNT_EN
         cnt_q     <= 5'd0;
         hit_count <= 5'd0;
`endif
      end else begin
         state    <= state_n;
         k        <= k_n;
         block_q  <= block_n;
         field_q  <= field_n;
         pos_x_q  <= pos_x_n;
         pos_y_q  <= pos_y_n;
         rot_q    <= rot_n;
         found_q  <= found_n;
         work_x_q <= work_x_n;
         work_y_q <= work_y_n;
         busy     <= busy_n;
         done     <= done_n;
         fit      <= fit_n;
         hit_x    <= hit_x_n;
         hit_y    <= hit_y_n;
`ifdef PIECE_FIT_COUNT_EN
         cnt_q     <= cnt_n;
         hit_count <= hit_count_n;
`endif
      end
   end

endmodule

// File: tb/tb_piece_fit_checker.sv
// Directed self-checking bench for piece_fit_checker (FIELD_W=10, FIELD_H=20, POS_W=5).
// Expectations follow PIECE_FIT_COUNT_EN when the bench is built with that macro.
module tb_piece_fit_checker;

   localparam int unsigned FW = 10;
   localparam int unsigned FH = 20;
   localparam int unsigned PW = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [15:0]       block;
   logic [FW*FH-1:0]  field;
   logic [PW-1:0]     pos_x;
   logic [PW-1:0]     pos_y;
   logic [1:0]        rotate;
   logic              busy;
   logic              done;
   logic              fit;
   logic [PW:0]       hit_x;
   logic [PW:0]       hit_y;
`ifdef PIECE_FIT_COUNT_EN
   logic [4:0]        hit_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   piece_fit_checker #(
      .FIELD_W (FW),
      .FIELD_H (FH),
      .POS_W   (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .block     (block),
      .field     (field),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .rotate    (rotate),
      .busy      (busy),
      .done      (done),
      .fit       (fit),
      .hit_x     (hit_x),
      .hit_y     (hit_y)
`ifdef PIECE_FIT_COUNT_EN
      ,
      .hit_count (hit_count)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present inputs with start=1 and return right after the accept edge (cycle 1).
   task automatic launch(input logic [15:0] blk, input logic [FW*FH-1:0] fld,
                         input int px, input int py, input int rot);
      @(negedge clk);
      block  = blk;
      field  = fld;
      pos_x  = PW'(px);
      pos_y  = PW'(py);
      rotate = 2'(rot);
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic wait_done(inout int cyc);
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_vec(input string tag, input logic [15:0] blk, input logic [FW*FH-1:0] fld,
                          input int px, input int py, input int rot,
                          input int exp_fit, input int exp_hx, input int exp_hy,
                          input int exp_cyc_first, input int exp_cnt);
      int cyc;
      int exp_cyc;
`ifdef PIECE_FIT_COUNT_EN
      exp_cyc = 17;
`else
      exp_cyc = exp_cyc_first;
`endif
      launch(blk, fld, px, py, rot);
      cyc = 1;
      check_eq({tag, "_busy1"}, 32'(busy), 32'd1);
      wait_done(cyc);
      check_eq({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
      check_eq({tag, "_fit"}, 32'(fit), 32'(exp_fit));
      check_eq({tag, "_hit_x"}, 32'(hit_x), 32'(exp_hx));
      check_eq({tag, "_hit_y"}, 32'(hit_y), 32'(exp_hy));
`ifdef PIECE_FIT_COUNT_EN
      check_eq({tag, "_count"}, 32'(hit_count), 32'(exp_cnt));
`else
      if (exp_cnt < 0) $display("bad count argument in %s", tag);
`endif
      @(posedge clk);
      #1;
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_fit_hold"}, 32'(fit), 32'(exp_fit));
   endtask

   logic [FW*FH-1:0] fld_empty;
   logic [FW*FH-1:0] fld_b24;
   logic [FW*FH-1:0] fld_b30;
   logic [FW*FH-1:0] fld_full;

   initial begin
      int cyc;
      logic saw_done;

      fld_empty = '0;
      fld_b24   = '0;
      fld_b24[24] = 1'b1;
      fld_b30   = '0;
      fld_b30[30] = 1'b1;
      fld_full  = '1;

      rst = 1'b1;
      start = 1'b0;
      block = '0;
      field = '0;
      pos_x = '0;
      pos_y = '0;
      rotate = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_fit", 32'(fit), 32'd0);
      check_eq("reset_hit_x", 32'(hit_x), 32'd0);
      check_eq("reset_hit_y", 32'(hit_y), 32'd0);
`ifdef PIECE_FIT_COUNT_EN
      check_eq("reset_count", 32'(hit_count), 32'd0);
`endif
      rst = 1'b0;

      //       tag          block     field      px  py rot fit hx  hy cyc cnt
      run_vec("fit_0033",   16'h0033, fld_empty,  4,  0, 0, 1,  0,  0, 17, 0);
      run_vec("hit_1111",   16'h1111, fld_b24,    4,  0, 0, 0,  4,  2, 10, 1);
      run_vec("oob_x",      16'h000F, fld_empty,  8,  0, 0, 0, 10,  0,  4, 2);
      run_vec("rot1_oob_y", 16'h000F, fld_empty,  6, 17, 1, 0,  9, 20, 17, 1);
      run_vec("rot2_oob",   16'h0001, fld_empty,  9,  0, 2, 0, 12,  3, 17, 1);
      run_vec("rot3_field", 16'h0001, fld_b30,    0,  0, 3, 0,  0,  3, 14, 1);
      run_vec("full_fit",   16'hFFFF, fld_empty,  0,  0, 0, 1,  0,  0, 17, 0);
      run_vec("full_edge",  16'hFFFF, fld_empty,  7,  0, 0, 0, 10,  0,  5, 4);
      run_vec("empty_blk",  16'h0000, fld_full,  31, 31, 0, 1,  0,  0, 17, 0);

      // Inputs changed and start pulsed mid-scan must not disturb the check.
      launch(16'h0033, fld_empty, 4, 0, 0);
      cyc = 1;
      while (cyc < 3) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      block  = 16'hFFFF;
      field  = fld_full;
      pos_x  = 5'd30;
      pos_y  = 5'd30;
      rotate = 2'd2;
      start  = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      start  = 1'b0;
      check_eq("ignore_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      check_eq("ignore_cycle", 32'(cyc), 32'd17);
      check_eq("ignore_fit", 32'(fit), 32'd1);
      check_eq("ignore_hit_x", 32'(hit_x), 32'd0);
      check_eq("ignore_hit_y", 32'(hit_y), 32'd0);
      @(posedge clk);
      #1;

      // Reset in SCAN cycle 5 aborts the check with no done pulse.
      launch(16'h1111, fld_b24, 4, 0, 0);
      cyc = 1;
      while (cyc < 5) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_fit", 32'(fit), 32'd0);
      check_eq("abort_hit_x", 32'(hit_x), 32'd0);
      check_eq("abort_hit_y", 32'(hit_y), 32'd0);
`ifdef PIECE_FIT_COUNT_EN
      check_eq("abort_count", 32'(hit_count), 32'd0);
`endif
      saw_done = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done | busy;
      end
      check_eq("abort_quiet", 32'(saw_done), 32'd0);

      run_vec("recover",    16'h1111, fld_b24,    4,  0, 0, 0,  4,  2, 10, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/piece_fit_checker.md
PIECE_FIT_CHECKER -- requirements
Module: piece_fit_checker

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; no other clock or asynchronous input exists.
REQ-002 The parameters SHALL be:
- FIELD_W, default 10: playfield columns.
- FIELD_H, default 20: playfield rows.
- POS_W, default 5: width of the piece position inputs.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: request a fit check.
- block, in, 16: 4x4 piece bitmap; bit index by*4+bx.
- field, in, FIELD_W*FIELD_H: occupied cells; bit index y*FIELD_W+x.
- pos_x, in, POS_W: piece column origin, unsigned.
- pos_y, in, POS_W: piece row origin, unsigned.
- rotate, in, 2: quarter-turn count.
- busy, out, 1: check in progress.
- done, out, 1: one-cycle completion pulse.
- fit, out, 1: 1 means no collision.
- hit_x, out, POS_W+1: column of the first colliding cell.
- hit_y, out, POS_W+1: row of the first colliding cell.
- hit_count, out, 5: number of colliding cells (present only under REQ-021).

Function
REQ-004 On start=1 in IDLE, the block SHALL capture block, field, pos_x, pos_y and rotate into internal registers, clear its cell counter k, and enter SCAN.
REQ-005 start SHALL be ignored in the SCAN and DONE states, and captured inputs SHALL NOT change until the next accepted start.
REQ-006 The FSM SHALL have exactly three states:
- IDLE -> SCAN on start.
- SCAN -> DONE on the terminating cell.
- DONE -> IDLE unconditionally after one cycle.
REQ-007 In SCAN, one cell SHALL be evaluated per cycle, with bx=k[1:0], by=k[3:2], and k running from 0 to 15 ascending.
REQ-008 The source bit SHALL be selected by rotate:
- 0: by*4+bx.
- 1: 12+by-4*bx.
- 2: 15-4*by-bx.
- 3: 3-by+4*bx.
REQ-009 The cell coordinates x=pos_x+bx and y=pos_y+by SHALL be computed in POS_W+1 bits, with no wrap-around.
REQ-010 A cell SHALL collide when its source bit is 1 AND (x>=FIELD_W OR y>=FIELD_H OR field[y*FIELD_W+x]=1).
REQ-011 The field SHALL be indexed only when the cell is in bounds; out-of-bounds cells SHALL never read field.
REQ-012 The first colliding cell (lowest k) SHALL latch hit_x and hit_y; later collisions SHALL NOT overwrite them.
REQ-013 Cells whose source bit is 0 SHALL never collide; an all-zero block SHALL yield fit=1.
REQ-014 busy SHALL be 1 exactly while in SCAN.
REQ-015 done SHALL be 1 for exactly one cycle, in DONE.
REQ-016 At done, the block SHALL present fit=1 if no cell collided, otherwise fit=0; fit, hit_x, hit_y and hit_count SHALL hold until the next done.
REQ-017 With no collision, done SHALL be high in cycle 17 after the start-accept edge (16 SCAN cycles plus DONE).
REQ-018 When fit=1, hit_x and hit_y SHALL be 0.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- set busy=0, done=0, fit=0, hit_x=0, hit_y=0, hit_count=0 and k=0.
REQ-020 Reset SHALL take priority over start and over a SCAN in progress; an aborted check SHALL produce no done pulse.

Configuration
REQ-021 With macro PIECE_FIT_COUNT_EN defined:
- SCAN SHALL always visit all 16 cells.
- hit_count SHALL report the total number of colliding cells (0-16).
- done SHALL always occur in cycle 17.
REQ-022 Without PIECE_FIT_COUNT_EN:
- port hit_count SHALL be absent.
- SCAN SHALL terminate on the cycle it finds the first collision at cell k.
- done SHALL be high in cycle k+2 after the start-accept edge.

Verification (FIELD_W=10, FIELD_H=20, POS_W=5)
REQ-023 Empty field, block=0x0033, pos=(4,0), rotate=0 -> done in cycle 17, fit=1, hit=(0,0), hit_count=0.
REQ-024 field bit 24 set, block=0x1111, pos=(4,0), rotate=0 -> fit=0, hit=(4,2).
- Without the macro: done in cycle 10.
- With the macro: done in cycle 17, hit_count=1.
REQ-025 Empty field, block=0x000F, pos=(8,0), rotate=0 -> fit=0, hit=(10,0); with the macro, hit_count=2.
REQ-026 Empty field, block=0x000F, pos=(6,17), rotate=1 -> fit=0, hit=(9,20).
- Without the macro: done in cycle 17.
- With the macro: hit_count=1.
REQ-027 Start and accept a check, then:
- change the inputs and pulse start in SCAN cycle 3 -> both are ignored, and the results reflect the original inputs.
- on a second run, assert rst in SCAN cycle 5 -> busy=0 on the next cycle, no done pulse, all outputs 0.
